memory_sequencer: RTL



---
 rtl/tau_mem_pkg.sv | 34 +++
 rtl/wait_state_counter.sv | 29 ++
 rtl/memory_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tau_mem_pkg.sv
// Shared types and decode helpers for the load/store memory sequencer.
package tau_mem_pkg;

  // Operation codes issued by the microcode sequencer; any other value is illegal.
  typedef enum logic [2:0] {
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_LOADV  = 3'd3,
    OP_STOREV = 3'd4,
    OP_PEEK   = 3'd5
  } load_store_op_set;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } mem_state_t;

  localparam int unsigned WAIT_WIDTH = 4;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_LOADV, OP_STOREV, OP_PEEK};
  endfunction

  // LOADV/STOREV go to v-RAM; LOAD/STORE/PEEK go to p-RAM.
  function automatic logic is_v_target(input logic [2:0] op);
    return (op == OP_LOADV) || (op == OP_STOREV);
  endfunction

  function automatic logic is_store_op(input logic [2:0] op);
    return (op == OP_STORE) || (op == OP_STOREV);
  endfunction

endpackage

// File: rtl/wait_state_counter.sv
// Loadable down-counter with a zero flag; counts RAM wait states for a bus access.
module wait_state_counter
  import tau_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [WAIT_WIDTH-1:0] i_load_value,
  input  logic                  i_dec,
  output logic                  o_zero
);

  logic [WAIT_WIDTH-1:0] r_count;

  // Load takes priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/memory_sequencer.sv
// Handshaked load/store sequencer: one request at a time, drives p-RAM or v-RAM
// for a configurable number of wait states, then returns a one-cycle response.
module memory_sequencer
  import tau_mem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned P_WAIT_STATES = 0,
  parameter int unsigned V_WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] pc_address,
  input  logic [ADDRESS_WIDTH-1:0] input_address,
  input  logic [DATA_WIDTH-1:0]    input_data,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_error,
  output logic                     p_ram_en,
  output logic                     p_ram_rw,
  output logic [ADDRESS_WIDTH-1:0] p_ram_address,
  output logic [DATA_WIDTH-1:0]    p_ram_wdata,
  input  logic [DATA_WIDTH-1:0]    p_ram_rdata,
  output logic                     v_ram_en,
  output logic                     v_ram_rw,
  output logic [ADDRESS_WIDTH-1:0] v_ram_address,
  output logic [DATA_WIDTH-1:0]    v_ram_wdata,
  input  logic [DATA_WIDTH-1:0]    v_ram_rdata
);

  localparam logic [WAIT_WIDTH-1:0] P_WS = WAIT_WIDTH'(P_WAIT_STATES);
  localparam logic [WAIT_WIDTH-1:0] V_WS = WAIT_WIDTH'(V_WAIT_STATES);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  mem_state_t r_state, w_next_state;

  logic                     r_is_v, w_next_is_v;
  logic                     r_is_store, w_next_is_store;
  logic                     r_rsp_valid, w_next_rsp_valid;
  logic                     r_rsp_error, w_next_rsp_error;
  logic [DATA_WIDTH-1:0]    r_rsp_data, w_next_rsp_data;
  logic                     r_p_en, w_next_p_en;
  logic                     r_v_en, w_next_v_en;
  logic                     r_rw, w_next_rw;
  logic [ADDRESS_WIDTH-1:0] r_addr, w_next_addr;
  logic [DATA_WIDTH-1:0]    r_wdata, w_next_wdata;

  logic                     w_cnt_load;
  logic [WAIT_WIDTH-1:0]    w_cnt_value;
  logic                     w_cnt_dec;
  logic                     w_cnt_zero;
  logic                     w_op_is_v;
  logic [ADDRESS_WIDTH-1:0] w_req_addr;

  wait_state_counter u_wait_counter (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_cnt_load),
    .i_load_value (w_cnt_value),
    .i_dec        (w_cnt_dec),
    .o_zero       (w_cnt_zero)
  );

  // Request decode: target RAM and effective address (PEEK reads PC+1, wrapping).
  assign w_op_is_v  = is_v_target(req_op);
  assign w_req_addr = (req_op == OP_PEEK) ? (pc_address + ADDR_ONE) : input_address;

  // Next-state and next-output decode for the sequencer FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    w_next_state     = r_state;
    w_next_is_v      = r_is_v;
    w_next_is_store  = r_is_store;
    w_next_rsp_valid = 1'b0;
    w_next_rsp_error = 1'b0;
    w_next_rsp_data  = r_rsp_data;
    w_next_p_en      = 1'b0;
    w_next_v_en      = 1'b0;
    w_next_rw        = 1'b0;
    w_next_addr      = '0;
    w_next_wdata     = '0;
    w_cnt_load       = 1'b0;
    w_cnt_value      = '0;
    w_cnt_dec        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_legal_op(req_op)) begin
            w_next_state    = ST_ACCESS;
            w_next_is_v     = w_op_is_v;
            w_next_is_store = is_store_op(req_op);
            w_next_p_en     = !w_op_is_v;
            w_next_v_en     = w_op_is_v;
            w_next_rw       = is_store_op(req_op);
            w_next_addr     = w_req_addr;
            w_next_wdata    = input_data;
            w_cnt_load      = 1'b1;
            w_cnt_value     = w_op_is_v ? V_WS : P_WS;
          end else begin
            w_next_state     = ST_RESPOND;
            w_next_rsp_valid = 1'b1;
            w_next_rsp_error = 1'b1;
            w_next_rsp_data  = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (w_cnt_zero) begin
          // Last enabled cycle: read data is valid now, release the RAM.
          w_next_state     = ST_RESPOND;
          w_next_rsp_valid = 1'b1;
          if (r_is_store) begin
            w_next_rsp_data = '0;
          end else begin
            w_next_rsp_data = r_is_v ? v_ram_rdata : p_ram_rdata;
          end
        end else begin
          w_next_p_en  = r_p_en;
          w_next_v_en  = r_v_en;
          w_next_rw    = r_rw;
          w_next_addr  = r_addr;
          w_next_wdata = r_wdata;
          w_cnt_dec    = 1'b1;
        end
      end
      ST_RESPOND: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update; reset aborts any access silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_is_v      <= 1'b0;
      r_is_store  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= '0;
      r_p_en      <= 1'b0;
      r_v_en      <= 1'b0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_is_v      <= w_next_is_v;
      r_is_store  <= w_next_is_store;
      r_rsp_valid <= w_next_rsp_valid;
      r_rsp_error <= w_next_rsp_error;
      r_rsp_data  <= w_next_rsp_data;
      r_p_en      <= w_next_p_en;
      r_v_en      <= w_next_v_en;
      r_rw        <= w_next_rw;
      r_addr      <= w_next_addr;
      r_wdata     <= w_next_wdata;
    end
  end

  // Ready is decoded from state and suppressed while reset is asserted.
  assign req_ready = (r_state == ST_IDLE) && !rst;

  assign rsp_valid     = r_rsp_valid;
  assign rsp_error     = r_rsp_error;
  assign rsp_data      = r_rsp_data;
  assign p_ram_en      = r_p_en;
  assign p_ram_rw      = r_p_en & r_rw;
  assign p_ram_address = r_p_en ? r_addr : '0;
  assign p_ram_wdata   = r_p_en ? r_wdata : '0;
  assign v_ram_en      = r_v_en;
  assign v_ram_rw      = r_v_en & r_rw;
  assign v_ram_address = r_v_en ? r_addr : '0;
  assign v_ram_wdata   = r_v_en ? r_wdata : '0;

endmodule
